servgrid_host_bridge: RTL and testbench
=======================================

# servgrid_host_bridge

Registered Wishbone host-to-grid bridge for the parametrised SERV tile grid. It sits between the single host/debug Wishbone master and the `nrow*ncol` servant tiles. It decodes the tile index from the address and drives exactly one tile strobe for unicast, or all tile strobes for broadcast writes. It collects per-tile acks and returns one host ack, or an error on bad index, broadcast read, or timeout.

## Interface
- `nrow`, 4, grid rows
- `ncol`, 4, grid columns; `ntile = nrow*ncol`, tile index = `ncol*row + col`
- `tile_lsb`, 16, LSB of tile-index field; field width `tw = max(1,$clog2(ntile))`
- `bcast_bit`, 31, address bit selecting broadcast write
- `timeout`, 255, max cycles waiting for tile acks before error (1..65535)

Ports:
- `wb_clk`  in  1  clock
- `wb_rst`  in  1  reset, asynchronous, active-high
- `i_wb_adr`  in  32  host address
- `i_wb_dat`  in  32  host write data
- `i_wb_sel`  in  4  byte selects
- `i_wb_we`  in  1  write enable
- `i_wb_stb`  in  1  host strobe (classic Wishbone, held until ack/err)
- `o_wb_rdt`  out  32  read data, valid with `o_wb_ack`
- `o_wb_ack`  out  1  one-cycle completion
- `o_wb_err`  out  1  one-cycle error completion
- `o_tile_adr`  out  32  registered address, shared to all tiles
- `o_tile_dat`  out  32  registered write data, shared
- `o_tile_sel`  out  4  registered selects, shared
- `o_tile_we`  out  1  registered write enable, shared
- `o_tile_stb`  out  ntile  per-tile strobe
- `i_tile_rdt`  in  32*ntile  tile read data, tile t at `[32*t +: 32]`
- `i_tile_ack`  in  ntile  per-tile ack

## Operation
- FSM states: IDLE, UNI, BCAST, RESP, ERR.
- IDLE: when `i_wb_stb` is high, register adr/dat/sel/we and decode.
  - `adr[bcast_bit]` high with `we` high goes to BCAST with `pend = all ones`.
  - `adr[bcast_bit]` high with `we` low goes to ERR.
  - Index `>= ntile` goes to ERR.
  - Otherwise go to UNI with `pend` = one-hot of the index.
- `o_tile_stb = pend` in UNI/BCAST; zero in every other state.
- UNI/BCAST: every cycle, `pend &= ~i_tile_ack`.
  - In UNI, an ack on the addressed tile captures its `i_tile_rdt` into the read register.
  - BCAST sets the read register to 0.
  - When `pend` becomes zero, go to RESP.
  - Acks on non-pending tiles are ignored.
- Timeout counter: cleared on entry to UNI/BCAST, increments each cycle there. When it reaches `timeout` with `pend != 0`, go to ERR and clear `pend`. If the last ack and the timeout land in the same cycle, the ack wins (RESP).
- RESP: `o_wb_ack = 1` for one cycle, then IDLE.
- ERR: `o_wb_err = 1` for one cycle, `o_wb_rdt = 0`, then IDLE.
- `o_wb_rdt` shows the read register while `o_wb_ack` is high, and 0 otherwise.
- In IDLE the bridge never accepts a strobe during the cycle immediately following RESP/ERR. That cycle is spent in IDLE with `stb` ignored; this gives the host its deassert cycle.
- Reset, async, any state: state IDLE, `pend = 0`, counter 0, registers 0. All outputs 0 immediately, including `o_tile_stb`, even mid-transaction. Reset release never produces a spurious ack or err.

## Timing
- Cycle 0: host `stb` sampled in IDLE.
- Cycle 1: `o_tile_stb` high, tile fields stable.
- Tile ack in cycle k (k ≥ 1): that tile's strobe is low in cycle k+1.
- Host ack in cycle k+1 (unicast), or one cycle after the last ack (broadcast). Unicast with a same-cycle tile ack gives host ack at cycle 2.
- Error on decode: `o_wb_err` at cycle 1, no tile strobe ever raised.
- Timeout error: `o_wb_err` at cycle `timeout+1`.
- Back-to-back: next request accepted no earlier than 2 cycles after the ack cycle.

## Structure
- Package `servgrid_pkg`: state enum, `tile_w` function (`clog2` with minimum 1), default `tile_lsb`/`bcast_bit` constants. The grid top shares these.
- Single module; no sub-module required. The next-generation grid top instantiates this bridge plus the servant tiles.

## Test plan
- Unicast read, 4x4, adr `0x0005_0010`, tile 5 acks at cycle 3 with `0xDEADBEEF`: `o_tile_stb = 16'h0020` cycles 1–3; host ack cycle 4 with `0xDEADBEEF`.
- Broadcast write adr `0x8000_0000`, tiles ack staggered at cycles 1..16: each strobe drops the cycle after its own ack; single host ack the cycle after the last ack; `rdt = 0`.
- Bad index: 3x3 grid, adr index 9 → `o_wb_err` at cycle 1, `o_tile_stb` never nonzero. Broadcast read → same.
- Timeout: `timeout = 8`, tile 2 never acks → err at cycle 9, strobe low at cycle 9, next request served normally.
- Reset asserted at cycle 2 of a broadcast → all outputs 0 asynchronously; after release, no ack/err until a new `stb`.
- Simultaneous: last broadcast ack in the same cycle the counter hits `timeout` → ack, not err.

Source files
------------

// File: rtl/servgrid_pkg.sv
// Shared definitions for the SERV tile grid: bridge FSM encoding, tile-index
// width helper and default address-map constants.
package servgrid_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_UNI   = 3'd1,
        S_BCAST = 3'd2,
        S_RESP  = 3'd3,
        S_ERR   = 3'd4
    } bridge_state_t;

    localparam int TILE_LSB_DEFAULT  = 16;
    localparam int BCAST_BIT_DEFAULT = 31;

    // Width of the tile-index field; never narrower than one bit.
    function automatic int tile_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/servgrid_host_bridge.sv
// Registered Wishbone bridge from the single host master to the nrow*ncol
// servant tiles: unicast, broadcast write, ack collection, error and timeout.
module servgrid_host_bridge
    import servgrid_pkg::*;
#(
    parameter int nrow      = 4,
    parameter int ncol      = 4,
    parameter int tile_lsb  = TILE_LSB_DEFAULT,
    parameter int bcast_bit = BCAST_BIT_DEFAULT,
    parameter int timeout   = 255
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst,
    input  logic [31:0]             i_wb_adr,
    input  logic [31:0]             i_wb_dat,
    input  logic [3:0]              i_wb_sel,
    input  logic                    i_wb_we,
    input  logic                    i_wb_stb,
    output logic [31:0]             o_wb_rdt,
    output logic                    o_wb_ack,
    output logic                    o_wb_err,
    output logic [31:0]             o_tile_adr,
    output logic [31:0]             o_tile_dat,
    output logic [3:0]              o_tile_sel,
    output logic                    o_tile_we,
    output logic [nrow*ncol-1:0]    o_tile_stb,
    input  logic [32*nrow*ncol-1:0] i_tile_rdt,
    input  logic [nrow*ncol-1:0]    i_tile_ack,
    output logic [2:0]              o_dbg_state
);

    // Host handshake: classic Wishbone. The host holds i_wb_stb and its fields
    // until exactly one of o_wb_ack/o_wb_err pulses for one cycle, then drops
    // stb; the bridge ignores stb in the cycle right after that pulse.

    localparam int ntile = nrow * ncol;
    localparam int tw    = tile_w(ntile);
    localparam logic [tw:0]       ntile_v  = (tw+1)'(ntile);
    localparam logic [15:0]       cnt_last = 16'(timeout - 1);
    localparam logic [ntile-1:0]  pend_one = ntile'(1);

    bridge_state_t     state, state_n;
    logic [ntile-1:0]  pend, pend_n;
    logic [15:0]       cnt, cnt_n;
    logic              hold;
    logic              accept;
    logic [tw-1:0]     idx;
    logic [31:0]       rd_reg, rd_cap;
    logic              capture;

    assign idx = i_wb_adr[tile_lsb +: tw];

    // State register
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state <= S_IDLE;
            pend  <= '0;
            cnt   <= '0;
            hold  <= 1'b0;
        end else begin
            state <= state_n;
            pend  <= pend_n;
            cnt   <= cnt_n;
            hold  <= (state == S_RESP) || (state == S_ERR);
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        pend_n  = pend;
        cnt_n   = cnt;
        accept  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_wb_stb && !hold) begin
                    accept = 1'b1;
                    cnt_n  = '0;
                    if (i_wb_adr[bcast_bit]) begin
                        if (i_wb_we) begin
                            state_n = S_BCAST;
                            pend_n  = '1;
                        end else begin
                            state_n = S_ERR;
                        end
                    end else if ({1'b0, idx} >= ntile_v) begin
                        state_n = S_ERR;
                    end else begin
                        state_n = S_UNI;
                        pend_n  = pend_one << idx;
                    end
                end
            end
            S_UNI, S_BCAST: begin
                pend_n = pend & ~i_tile_ack;
                cnt_n  = cnt + 16'd1;
                // A final ack in the timeout cycle still completes normally.
                if (pend_n == '0) begin
                    state_n = S_RESP;
                end else if (cnt == cnt_last) begin
                    state_n = S_ERR;
                    pend_n  = '0;
                end
            end
            S_RESP, S_ERR: state_n = S_IDLE;
            default: begin
                state_n = S_IDLE;
                pend_n  = '0;
            end
        endcase
    end

    always_comb begin
        rd_cap = '0;
        for (int t = 0; t < ntile; t++) begin
            if (pend[t] && i_tile_ack[t]) begin
                rd_cap = rd_cap | i_tile_rdt[32*t +: 32];
            end
        end
    end

    assign capture = |(pend & i_tile_ack);

    // Shared tile fields and read register; cleared on accept so broadcast reads back 0.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            o_tile_adr <= '0;
            o_tile_dat <= '0;
            o_tile_sel <= '0;
            o_tile_we  <= 1'b0;
            rd_reg     <= '0;
        end else if (accept) begin
            o_tile_adr <= i_wb_adr;
            o_tile_dat <= i_wb_dat;
            o_tile_sel <= i_wb_sel;
            o_tile_we  <= i_wb_we;
            rd_reg     <= '0;
        end else if (state == S_UNI && capture) begin
            rd_reg <= rd_cap;
        end
    end

    // Output logic
    always_comb begin
        o_tile_stb  = ((state == S_UNI) || (state == S_BCAST)) ? pend : '0;
        o_wb_ack    = (state == S_RESP);
        o_wb_err    = (state == S_ERR);
        o_wb_rdt    = o_wb_ack ? rd_reg : 32'h0;
        o_dbg_state = state;
    end

endmodule

// File: tb/tb_servgrid_host_bridge.sv
// Directed bench for servgrid_host_bridge: a 4x4 grid (timeout 20) and a
// 3x3 grid (timeout 8) sharing clock and reset.
module tb_servgrid_host_bridge;

  localparam int W = 34;

  logic wb_clk = 1'b0;
  logic wb_rst = 1'b1;

  logic [31:0]  a_adr, a_dat, a_rdt, a_tadr, a_tdat;
  logic [3:0]   a_sel, a_tsel;
  logic         a_we, a_stb, a_ack, a_err, a_twe;
  logic [15:0]  a_tstb, a_tack;
  logic [511:0] a_trdt;
  logic [2:0]   a_dbg;

  logic [31:0]  b_adr, b_dat, b_rdt, b_tadr, b_tdat;
  logic [3:0]   b_sel, b_tsel;
  logic         b_we, b_stb, b_ack, b_err, b_twe;
  logic [8:0]   b_tstb, b_tack;
  logic [287:0] b_trdt;
  logic [2:0]   b_dbg;

  logic [W-1:0] exp_q[$];
  logic [31:0]  tdata[16];
  int           ac[16];
  int           vectors = 0;
  int           miscompares = 0;

  servgrid_host_bridge #(.nrow(4), .ncol(4), .timeout(20)) dut_a (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .i_wb_adr(a_adr), .i_wb_dat(a_dat), .i_wb_sel(a_sel), .i_wb_we(a_we), .i_wb_stb(a_stb),
    .o_wb_rdt(a_rdt), .o_wb_ack(a_ack), .o_wb_err(a_err),
    .o_tile_adr(a_tadr), .o_tile_dat(a_tdat), .o_tile_sel(a_tsel), .o_tile_we(a_twe),
    .o_tile_stb(a_tstb), .i_tile_rdt(a_trdt), .i_tile_ack(a_tack), .o_dbg_state(a_dbg)
  );

  servgrid_host_bridge #(.nrow(3), .ncol(3), .timeout(8)) dut_b (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .i_wb_adr(b_adr), .i_wb_dat(b_dat), .i_wb_sel(b_sel), .i_wb_we(b_we), .i_wb_stb(b_stb),
    .o_wb_rdt(b_rdt), .o_wb_ack(b_ack), .o_wb_err(b_err),
    .o_tile_adr(b_tadr), .o_tile_dat(b_tdat), .o_tile_sel(b_tsel), .o_tile_we(b_twe),
    .o_tile_stb(b_tstb), .i_tile_rdt(b_trdt), .i_tile_ack(b_tack), .o_dbg_state(b_dbg)
  );

  // Clock / watchdog
  always #5 wb_clk = ~wb_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_host(input int inst, input logic [31:0] adr, dat,
                            input logic [3:0] sel, input logic we, stb);
    if (inst == 0) begin
      a_adr = adr; a_dat = dat; a_sel = sel; a_we = we; a_stb = stb;
    end else begin
      b_adr = adr; b_dat = dat; b_sel = sel; b_we = we; b_stb = stb;
    end
  endtask

  task automatic drive_tiles(input int inst, input logic [15:0] ackv);
    if (inst == 0) begin
      a_tack = ackv;
      for (int t = 0; t < 16; t++) a_trdt[32*t +: 32] = tdata[t];
    end else begin
      b_tack = ackv[8:0];
      for (int t = 0; t < 9; t++) b_trdt[32*t +: 32] = tdata[t];
    end
  endtask

  task automatic sample(input int inst, output logic [15:0] stb, output logic ack, err,
                        output logic [31:0] rdt, tadr, output logic [36:0] trest);
    if (inst == 0) begin
      stb = a_tstb; ack = a_ack; err = a_err; rdt = a_rdt; tadr = a_tadr;
      trest = {a_tdat, a_tsel, a_twe};
    end else begin
      stb = {7'b0, b_tstb}; ack = b_ack; err = b_err; rdt = b_rdt; tadr = b_tadr;
      trest = {b_tdat, b_tsel, b_twe};
    end
  endtask

  task automatic clear_ac();
    for (int t = 0; t < 16; t++) ac[t] = -1;
  endtask

  // One host transaction. Cycle 0 is the cycle whose closing edge accepts stb.
  // Tile t acks in cycle ack_cyc[t]; mask is the expected strobe set in cycle 1.
  task automatic txn(input int inst, input logic [31:0] adr, dat, input logic [3:0] sel,
                     input logic we, input logic [15:0] mask, input int ack_cyc[16],
                     input int done_c, input logic [W-1:0] resp, input bit early);
    logic [15:0]  pend_m, ackv, stb_o;
    logic         ack_o, err_o;
    logic [31:0]  rdt_o, tadr_o;
    logic [36:0]  trest_o;
    logic [W-1:0] exp_r;
    bit           done;
    if (!early) @(negedge wb_clk);
    exp_q.push_back(resp);
    drive_host(inst, adr, dat, sel, we, 1'b1);
    drive_tiles(inst, 16'h0);
    if (early) begin
      @(negedge wb_clk);
      sample(inst, stb_o, ack_o, err_o, rdt_o, tadr_o, trest_o);
      check("hold_cycle_ignored", {ack_o, err_o, stb_o}, 18'h0);
    end
    sample(inst, stb_o, ack_o, err_o, rdt_o, tadr_o, trest_o);
    check("idle_stb", stb_o, 16'h0);
    pend_m = mask;
    done = 1'b0;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge wb_clk);
      sample(inst, stb_o, ack_o, err_o, rdt_o, tadr_o, trest_o);
      check("tile_stb", stb_o, (c == done_c) ? 16'h0 : pend_m);
      if (c == 1) begin
        check("tile_adr", tadr_o, adr);
        check("tile_dat_sel_we", trest_o, {dat, sel, we});
      end
      if (ack_o || err_o) begin
        done = 1'b1;
        exp_r = exp_q.pop_front();
        check("host_resp", {ack_o, err_o, rdt_o}, exp_r);
        check("resp_cycle", c, done_c);
        drive_host(inst, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        drive_tiles(inst, 16'h0);
      end else begin
        ackv = '0;
        for (int t = 0; t < 16; t++) if (ack_cyc[t] == c) ackv[t] = 1'b1;
        pend_m = pend_m & ~ackv;
        drive_tiles(inst, ackv);
      end
    end
    check("resp_seen", done, 1'b1);
    if (!done) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      drive_host(inst, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      drive_tiles(inst, 16'h0);
    end
    @(negedge wb_clk);
  endtask

  initial begin
    int          t, o, k;
    logic [31:0] adr;
    logic [15:0] stb_o;
    logic        ack_o, err_o, seen;
    logic [31:0] rdt_o, tadr_o;
    logic [36:0] trest_o;

    for (int i = 0; i < 16; i++) tdata[i] = 32'hC0DE_0000 | 32'(i);
    drive_host(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    drive_host(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    drive_tiles(0, 16'h0);
    drive_tiles(1, 16'h0);
    clear_ac();

    // Reset state
    #3;
    sample(0, stb_o, ack_o, err_o, rdt_o, tadr_o, trest_o);
    check("reset_a_outputs", {stb_o, ack_o, err_o, rdt_o}, 50'h0);
    check("reset_a_fields", {tadr_o, trest_o}, 69'h0);
    check("reset_a_state", a_dbg, 3'd0);
    sample(1, stb_o, ack_o, err_o, rdt_o, tadr_o, trest_o);
    check("reset_b_outputs", {stb_o, ack_o, err_o, rdt_o}, 50'h0);
    @(negedge wb_clk);
    @(negedge wb_clk);
    wb_rst = 1'b0;

    // 4x4 unicast read, tile 5 acks in cycle 3
    tdata[5] = 32'hDEADBEEF;
    clear_ac(); ac[5] = 3;
    txn(0, 32'h0005_0010, 32'h1234_5678, 4'hF, 1'b0, 16'h0020, ac, 4, {2'b10, 32'hDEADBEEF}, 1'b0);

    // Unicast with an ack in cycle 1
    clear_ac(); ac[0] = 1;
    txn(0, 32'h0000_0000, 32'h0, 4'h1, 1'b0, 16'h0001, ac, 2, {2'b10, tdata[0]}, 1'b0);

    // Broadcast write, tile t acks in cycle t+1
    clear_ac();
    for (int i = 0; i < 16; i++) ac[i] = i + 1;
    txn(0, 32'h8000_0000, 32'hCAFE_F00D, 4'h3, 1'b1, 16'hFFFF, ac, 17, {2'b10, 32'h0}, 1'b0);

    // Random unicasts; a neighbour acks too and must be ignored. First is back-to-back.
    for (int i = 0; i < 4; i++) begin
      t = $urandom_range(0, 15);
      o = (t + 1) % 16;
      k = $urandom_range(1, 6);
      tdata[t] = $urandom;
      tdata[o] = $urandom;
      clear_ac(); ac[t] = k; ac[o] = k;
      adr = (32'(t) << 16) | 32'($urandom_range(0, 65535));
      txn(0, adr, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          16'h1 << t, ac, k + 1, {2'b10, tdata[t]}, i == 0);
    end

    // 3x3 decode errors: index 9, index 15, broadcast read
    clear_ac();
    txn(1, 32'h0009_0000, 32'h11, 4'hF, 1'b0, 16'h0, ac, 1, {2'b01, 32'h0}, 1'b0);
    txn(1, 32'h000F_0004, 32'h22, 4'hF, 1'b1, 16'h0, ac, 1, {2'b01, 32'h0}, 1'b0);
    txn(1, 32'h8000_0000, 32'h33, 4'hF, 1'b0, 16'h0, ac, 1, {2'b01, 32'h0}, 1'b0);

    // Timeout on tile 2, then an immediate normal request
    txn(1, 32'h0002_0000, 32'h44, 4'hF, 1'b0, 16'h0004, ac, 9, {2'b01, 32'h0}, 1'b0);
    clear_ac(); ac[4] = 2;
    txn(1, 32'h0004_0008, 32'h55, 4'h2, 1'b0, 16'h0010, ac, 3, {2'b10, tdata[4]}, 1'b1);

    // Last broadcast ack coincides with the timeout cycle: ack wins
    clear_ac();
    for (int i = 0; i < 8; i++) ac[i] = i + 1;
    ac[8] = 8;
    txn(1, 32'h8000_0000, 32'h66, 4'hF, 1'b1, 16'h01FF, ac, 9, {2'b10, 32'h0}, 1'b0);

    // Asynchronous reset in cycle 2 of a broadcast
    @(negedge wb_clk);
    drive_host(0, 32'h8000_0000, 32'hA5A5_A5A5, 4'hF, 1'b1, 1'b1);
    drive_tiles(0, 16'h0);
    @(negedge wb_clk);
    @(negedge wb_clk);
    sample(0, stb_o, ack_o, err_o, rdt_o, tadr_o, trest_o);
    check("pre_reset_stb", stb_o, 16'hFFFF);
    #2 wb_rst = 1'b1;
    #1;
    sample(0, stb_o, ack_o, err_o, rdt_o, tadr_o, trest_o);
    check("async_rst_stb", stb_o, 16'h0);
    check("async_rst_resp", {ack_o, err_o, rdt_o}, 34'h0);
    check("async_rst_fields", {tadr_o, trest_o}, 69'h0);
    check("async_rst_state", a_dbg, 3'd0);
    drive_host(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    @(negedge wb_clk);
    @(negedge wb_clk);
    wb_rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge wb_clk);
      sample(0, stb_o, ack_o, err_o, rdt_o, tadr_o, trest_o);
      seen = seen | ack_o | err_o | (stb_o != 16'h0);
    end
    check("quiet_after_reset", seen, 1'b0);

    // Request after reset is served normally
    clear_ac(); ac[9] = 2;
    txn(0, 32'h0009_0000, 32'h77, 4'hF, 1'b0, 16'h0200, ac, 3, {2'b10, tdata[9]}, 1'b0);

    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
